// File: rtl/prm_pkg.sv
// Shared types for the program run monitor.
//   verdict_e : latched result code reported on the verdict port
//   state_e   : supervisor FSM states
//   classify  : maps the mailbox state at halt time onto a verdict
package prm_pkg;

    typedef enum logic [2:0] {
        V_NONE    = 3'd0,
        V_PASS    = 3'd1,
        V_FAIL    = 3'd2,
        V_UNKNOWN = 3'd3,
        V_TIMEOUT = 3'd4,
        V_STALL   = 3'd5
    } verdict_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Pass wins if both codes happen to be configured identically.
    function automatic verdict_e classify(logic valid, logic is_pass, logic is_fail);
        if (valid && is_pass) return V_PASS;
        if (valid && is_fail) return V_FAIL;
        return V_UNKNOWN;
    endfunction

endpackage

// File: rtl/prm_watchdog.sv
// Generic "value unchanged for LIMIT cycles" detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : forget history and zero the counter
//   enable     : sample value this cycle
//   value      : observed value
//   tripped    : combinational; this enabled cycle brings the count to LIMIT
// LIMIT = 0 disables the detector.
module prm_watchdog #(
    parameter int unsigned VALUE_W = 32,
    parameter int unsigned LIMIT   = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [VALUE_W-1:0] value,
    output logic               tripped
);

    localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [VALUE_W-1:0] prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        cnt_d      = cnt_q;
        tripped    = 1'b0;
        if (clear) begin
            // First enabled cycle after a clear has nothing to compare against.
            prev_vld_d = 1'b0;
            cnt_d      = '0;
        end else if (enable) begin
            prev_d     = value;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (value == prev_q)) begin
                if (cnt_q != LIMIT_C) cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
            end
            tripped = (LIMIT != 0) && (cnt_d == LIMIT_C);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: rtl/program_run_monitor.sv
// Run supervisor snooping a CPU's halt flag, PC and data-memory write bus.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : begin a fresh run / return to idle (abort wins)
//   system_halted, pc_in  : CPU halt flag and program counter
//   mem_wr_en/addr/data   : data-memory write bus, watched for the status mailbox
//   running, done         : FSM in RUN / DONE
//   verdict               : latched result (prm_pkg::verdict_e)
//   status_valid/code     : mailbox written this run / last value written
//   cycle_count           : RUN cycles elapsed, saturating at MAX_CYCLES
//   progress_pulse/pc     : strobe every PROGRESS_INTERVAL cycles, PC captured then
module program_run_monitor
    import prm_pkg::*;
#(
    parameter int unsigned       ADDR_W            = 32,
    parameter int unsigned       DATA_W            = 32,
    parameter int unsigned       CNT_W             = 32,
    parameter int unsigned       MAX_CYCLES        = 50000,
    parameter logic [ADDR_W-1:0] STATUS_ADDR       = ADDR_W'(32'h0000_2000),
    parameter logic [DATA_W-1:0] PASS_CODE         = DATA_W'(1),
    parameter logic [DATA_W-1:0] FAIL_CODE         = DATA_W'(0),
    parameter int unsigned       PROGRESS_INTERVAL = 100,
    parameter int unsigned       STALL_LIMIT       = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              system_halted,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic              running,
    output logic              done,
    output logic [2:0]        verdict,
    output logic              status_valid,
    output logic [DATA_W-1:0] status_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              progress_pulse,
    output logic [ADDR_W-1:0] progress_pc
);

    localparam int unsigned PW = (PROGRESS_INTERVAL < 2) ? 1 : $clog2(PROGRESS_INTERVAL);
    localparam logic [PW-1:0]    PROG_LAST = PW'(PROGRESS_INTERVAL - 1);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

    state_e            state_q, state_d;
    verdict_e          verdict_q, verdict_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic              sv_q, sv_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic [ADDR_W-1:0] ppc_q, ppc_d;
    // Separate modulo counter avoids a divider on cycle_count.
    logic [PW-1:0]     prog_q, prog_d;

    logic              in_run, begin_run, stall_trip;
    logic              wr_hit, sv_now, pulse;
    logic [DATA_W-1:0] code_now;
    logic [CNT_W-1:0]  cyc_inc;

    assign in_run    = (state_q == S_RUN) && !abort;
    assign begin_run = start && !abort && (state_q != S_RUN);

    prm_watchdog #(
        .VALUE_W (ADDR_W),
        .LIMIT   (STALL_LIMIT)
    ) u_stall (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (begin_run),
        .enable  (in_run),
        .value   (pc_in),
        .tripped (stall_trip)
    );

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        cyc_d     = cyc_q;
        sv_d      = sv_q;
        code_d    = code_q;
        ppc_d     = ppc_q;
        prog_d    = prog_q;
        pulse     = 1'b0;
        wr_hit    = mem_wr_en && (mem_wr_addr == STATUS_ADDR);
        // A mailbox write in the halt cycle must count toward the verdict.
        sv_now    = sv_q | wr_hit;
        code_now  = wr_hit ? mem_wr_data : code_q;
        cyc_inc   = cyc_q + CNT_W'(1);

        if (abort) begin
            state_d   = S_IDLE;
            verdict_d = V_NONE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d   = S_RUN;
                        verdict_d = V_NONE;
                        cyc_d     = '0;
                        sv_d      = 1'b0;
                        code_d    = '0;
                        prog_d    = '0;
                    end
                end
                S_RUN: begin
                    cyc_d  = cyc_inc;
                    sv_d   = sv_now;
                    code_d = code_now;
                    if ((PROGRESS_INTERVAL != 0) && (prog_q == PROG_LAST)) begin
                        pulse  = 1'b1;
                        prog_d = '0;
                        ppc_d  = pc_in;
                    end else begin
                        prog_d = prog_q + PW'(1);
                    end
                    // Priority: halt > timeout > stall.
                    if (system_halted) begin
                        state_d   = S_DONE;
                        verdict_d = classify(sv_now, code_now == PASS_CODE,
                                             code_now == FAIL_CODE);
                    end else if (cyc_inc == MAX_C) begin
                        state_d   = S_DONE;
                        verdict_d = V_TIMEOUT;
                    end else if (stall_trip) begin
                        state_d   = S_DONE;
                        verdict_d = V_STALL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            verdict_q <= V_NONE;
            cyc_q     <= '0;
            sv_q      <= 1'b0;
            code_q    <= '0;
            ppc_q     <= '0;
            prog_q    <= '0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            cyc_q     <= cyc_d;
            sv_q      <= sv_d;
            code_q    <= code_d;
            ppc_q     <= ppc_d;
            prog_q    <= prog_d;
        end
    end

    assign running        = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign verdict        = verdict_q;
    assign status_valid   = sv_q;
    assign status_code    = code_q;
    assign cycle_count    = cyc_q;
    assign progress_pulse = pulse;
    assign progress_pc    = ppc_q;

endmodule

// File: doc/program_run_monitor.md
Name: program_run_monitor

Overview:
Synthesisable run supervisor that sits beside microprocessor_system in simulation and FPGA bring-up builds. It snoops the CPU halt flag, PC and data-memory write bus. It counts execution cycles, captures the status-code mailbox write and enforces timeout and PC-stall watchdogs. It reports a single latched verdict (PASS/FAIL/UNKNOWN/TIMEOUT/STALL) and emits periodic progress pulses with a PC snapshot.

Parameters:
ADDR_W, 32, snooped address and PC width
DATA_W, 32, snooped write-data and status-code width
CNT_W, 32, cycle counter width
MAX_CYCLES, 50000, RUN-cycle budget before TIMEOUT; must be ≥1 and < 2^CNT_W
STATUS_ADDR, 32'h0000_2000, byte address of the status mailbox word
PASS_CODE, 1, mailbox value meaning pass
FAIL_CODE, 0, mailbox value meaning fail
PROGRESS_INTERVAL, 100, RUN cycles between progress pulses; 0 disables
STALL_LIMIT, 1024, consecutive cycles with unchanged PC that trigger STALL; 0 disables

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear and begin supervising
abort  in  1  return to IDLE; verdict cleared
system_halted  in  1  CPU halt flag
pc_in  in  ADDR_W  CPU program counter
mem_wr_en  in  1  data-memory write strobe
mem_wr_addr  in  ADDR_W  write byte address
mem_wr_data  in  DATA_W  write data
running  out  1  state == RUN
done  out  1  state == DONE
verdict  out  3  result code (package enum)
status_valid  out  1  mailbox written during this run
status_code  out  DATA_W  last mailbox value
cycle_count  out  CNT_W  RUN cycles elapsed
progress_pulse  out  1  one-cycle progress strobe
progress_pc  out  ADDR_W  pc_in sampled at the last progress pulse

Behaviour:
- Reset sets state IDLE and all outputs 0; verdict = V_NONE (0).
- FSM IDLE→RUN on start. RUN→DONE on halt, timeout or stall. DONE→RUN on start. Any state→IDLE on abort. Abort beats start.
- Entering RUN clears cycle_count, status_valid, status_code, the stall counter and verdict; running=1 on the next cycle.
- RUN, each cycle: cycle_count += 1. Mailbox write (mem_wr_en && mem_wr_addr==STATUS_ADDR) latches mem_wr_data into status_code and sets status_valid; last write wins.
- Halt sampled in RUN: done and verdict appear the following cycle. A mailbox write in the halt cycle counts toward that verdict. Verdict = PASS if status_valid && code==PASS_CODE; FAIL if valid && code==FAIL_CODE; otherwise UNKNOWN. This includes no mailbox write.
- Timeout: cycle_count reaching MAX_CYCLES with no halt gives TIMEOUT. cycle_count stops at MAX_CYCLES.
- Stall: the counter increments when pc_in equals the previous cycle's pc_in and resets on any change. Reaching STALL_LIMIT gives STALL.
- Priority when triggers coincide: halt > timeout > stall.
- Progress: when PROGRESS_INTERVAL≠0 and the post-increment cycle_count mod interval == 0, progress_pulse=1 for that cycle and progress_pc captures pc_in. Never pulses outside RUN.
- DONE holds every output frozen and ignores snoop inputs.
- IDLE ignores snoop inputs.
- Asynchronous reset mid-run returns everything to reset values immediately.

Decomposition:
- Package prm_pkg holds the verdict enum: V_NONE=0, V_PASS=1, V_FAIL=2, V_UNKNOWN=3, V_TIMEOUT=4, V_STALL=5. It also holds the state enum: S_IDLE, S_RUN, S_DONE.
- One sub-module, prm_watchdog: a generic "value unchanged for N cycles" counter, used for the stall detector.

Test Plan:
- MAX_CYCLES=50000. start, mailbox write 1 to 0x2000 at cycle 40, halt at cycle 57 → done, verdict=PASS, status_code=1, cycle_count=57.
- Mailbox write 0 and halt in the same cycle 10 → verdict=FAIL, status_valid=1.
- Write 7, then write 1, then halt; halt with no write → PASS (last wins); UNKNOWN for the halt-only run.
- MAX_CYCLES=200, no halt, PC incrementing → verdict=TIMEOUT after exactly 200 RUN cycles. progress_pulse at counts 100 and 200, with progress_pc matching.
- PC held at 0x8010 with STALL_LIMIT=16 → STALL 16 cycles after the hold began. Halt asserted on the trigger cycle → PASS/UNKNOWN instead (priority).
- abort mid-RUN → IDLE, verdict=0. start from DONE → counters cleared, fresh run. rst_n low mid-run → all outputs 0 asynchronously.
